// File: rtl/axi_stream_width_down_pkg.sv
// Shared types and beat-count helpers for AXI-stream width converters.
package axi_stream_width_down_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ISSUE = 1'b1
  } hold_state_e;

  // A one-byte bus still carries a 1-bit mod field.
  function automatic int mod_width(input int byts);
    return (byts > 1) ? $clog2(byts) : 1;
  endfunction

  function automatic int eop_bytes(input int mod, input logic eop, input int in_byts);
    if (!eop || mod == 0) return in_byts;
    return mod;
  endfunction

  function automatic int beats_from_mod(input int mod, input logic eop,
                                        input int in_byts, input int out_byts);
    return (eop_bytes(mod, eop, in_byts) + out_byts - 1) / out_byts;
  endfunction

  function automatic int last_mod(input int mod, input logic eop,
                                  input int in_byts, input int out_byts);
    return eop_bytes(mod, eop, in_byts) % out_byts;
  endfunction

endpackage

// File: rtl/axi_stream_width_down_if.sv
// AXI-stream bus bundle with packet sideband (sop/eop/mod/err/ctl).
interface if_axi_stream import axi_stream_width_down_pkg::*; #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
) ();
  localparam int DAT_BITS = DAT_BYTS * 8;
  localparam int MOD_BITS = mod_width(DAT_BYTS);

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, sop, eop, err, dat, mod, ctl, input rdy);
  modport sink   (input val, sop, eop, err, dat, mod, ctl, output rdy);
endinterface

// File: rtl/axi_stream_width_down.sv
// Narrowing AXI-stream converter: one wide beat out as N narrow beats, LSB first.
// Optional protocol checker enabled by defining AXIS_WIDTH_DOWN_PROTO_CHK_EN.
module axi_stream_width_down import axi_stream_width_down_pkg::*; #(
  parameter int IN_DAT_BYTS  = 8,
  parameter int OUT_DAT_BYTS = 2,
  parameter int CTL_BITS     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  if_axi_stream.sink   i_axi,
  if_axi_stream.source o_axi
`ifdef AXIS_WIDTH_DOWN_PROTO_CHK_EN
  ,
  output logic         o_proto_err
`endif
);
  localparam int R         = IN_DAT_BYTS / OUT_DAT_BYTS;
  localparam int CNT_W     = $clog2(R) + 1;
  localparam int IN_BITS   = IN_DAT_BYTS * 8;
  localparam int OUT_BITS  = OUT_DAT_BYTS * 8;
  localparam int OUT_MOD_W = mod_width(OUT_DAT_BYTS);

  if ((IN_DAT_BYTS % OUT_DAT_BYTS) != 0) begin : g_bad_ratio
    $fatal(1, "IN_DAT_BYTS must be an integer multiple of OUT_DAT_BYTS");
  end

  hold_state_e          state_q, state_d;
  logic [IN_BITS-1:0]   dat_q, dat_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 err_q, err_d;
  logic [CTL_BITS-1:0]  ctl_q, ctl_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     k_q, k_d;
  logic [OUT_MOD_W-1:0] lmod_q, lmod_d;

  logic last_beat;
  logic out_xfer;
  logic in_rdy;
  logic in_xfer;
  logic out_eop;

  assign last_beat = (k_q == n_q - CNT_W'(1));
  assign out_xfer  = (state_q == ST_ISSUE) && o_axi.rdy;
  // Reload on the same edge the last slice leaves, so back-to-back beats never bubble.
  assign in_rdy    = i_rst && ((state_q == ST_EMPTY) || (o_axi.rdy && last_beat));
  assign in_xfer   = i_axi.val && in_rdy;
  assign i_axi.rdy = in_rdy;

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = err_q;
    ctl_d   = ctl_q;
    n_d     = n_q;
    k_d     = k_q;
    lmod_d  = lmod_q;
    if (in_xfer) begin
      state_d = ST_ISSUE;
      dat_d   = i_axi.dat;
      sop_d   = i_axi.sop;
      eop_d   = i_axi.eop;
      err_d   = i_axi.err;
      ctl_d   = i_axi.ctl;
      n_d     = CNT_W'(beats_from_mod(int'(i_axi.mod), i_axi.eop, IN_DAT_BYTS, OUT_DAT_BYTS));
      lmod_d  = OUT_MOD_W'(last_mod(int'(i_axi.mod), i_axi.eop, IN_DAT_BYTS, OUT_DAT_BYTS));
      k_d     = '0;
    end else if (out_xfer) begin
      if (last_beat) begin
        state_d = ST_EMPTY;
        k_d     = '0;
      end else begin
        k_d = k_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_EMPTY;
      dat_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      lmod_q  <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
      n_q     <= n_d;
      k_q     <= k_d;
      lmod_q  <= lmod_d;
    end
  end

  assign out_eop   = eop_q && last_beat;
  assign o_axi.val = (state_q == ST_ISSUE);
  assign o_axi.dat = dat_q[k_q*OUT_BITS +: OUT_BITS];
  assign o_axi.sop = sop_q && (k_q == '0);
  assign o_axi.eop = out_eop;
  assign o_axi.mod = out_eop ? lmod_q : '0;
  assign o_axi.err = err_q;
  assign o_axi.ctl = ctl_q;

`ifdef AXIS_WIDTH_DOWN_PROTO_CHK_EN
  logic in_pkt_q, in_pkt_d;
  logic proto_err_q, proto_err_d;

  // A legal beat has sop exactly when no packet is open.
  always_comb begin
    in_pkt_d    = in_pkt_q;
    proto_err_d = proto_err_q;
    if (in_xfer) begin
      if (i_axi.sop == in_pkt_q) proto_err_d = 1'b1;
      in_pkt_d = !i_axi.eop;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_pkt_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign o_proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_axi_stream_width_down.sv
// Directed bench for axi_stream_width_down (8-byte in, 2-byte out).
module tb_axi_stream_width_down;
  localparam int IN_B  = 8;
  localparam int OUT_B = 2;
  localparam int CTL_W = 8;

  typedef struct {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [7:0]  ctl;
    logic        err;
  } ibeat_t;

  typedef struct {
    ibeat_t in;
    int     exp_n;
    logic   exp_lmod;
  } vec_t;

  typedef struct {
    logic [15:0] dat;
    logic        sop;
    logic        eop;
    logic        err;
    logic [0:0]  mod;
    logic [7:0]  ctl;
    int          cyc;
  } obeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   bp_en = 1'b0;
  obeat_t mon_q[$];
  obeat_t mb;

  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(IN_B), .CTL_BITS(CTL_W))  in_if ();
  if_axi_stream #(.DAT_BYTS(OUT_B), .CTL_BITS(CTL_W)) out_if ();

`ifdef AXIS_WIDTH_DOWN_PROTO_CHK_EN
  logic proto_err;
`endif

  axi_stream_width_down #(
    .IN_DAT_BYTS (IN_B),
    .OUT_DAT_BYTS(OUT_B),
    .CTL_BITS    (CTL_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_axi(in_if),
    .o_axi(out_if)
`ifdef AXIS_WIDTH_DOWN_PROTO_CHK_EN
    ,
    .o_proto_err(proto_err)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log every output transfer; the handshake is stable from negedge to the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_if.val && out_if.rdy) begin
      mb.dat = out_if.dat;
      mb.sop = out_if.sop;
      mb.eop = out_if.eop;
      mb.err = out_if.err;
      mb.mod = out_if.mod;
      mb.ctl = out_if.ctl;
      mb.cyc = cyc;
      mon_q.push_back(mb);
    end
  end

  initial begin
    out_if.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting posedge.
  task automatic drive_beat(input ibeat_t b);
    logic acc;
    in_if.val = 1'b1;
    in_if.dat = b.dat;
    in_if.sop = b.sop;
    in_if.eop = b.eop;
    in_if.mod = b.mod;
    in_if.ctl = b.ctl;
    in_if.err = b.err;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      acc = in_if.rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        in_if.val = 1'b0;
        return;
      end
    end
    in_if.val = 1'b0;
    checks++;
    errors++;
    $display("FAIL drive timeout: input not accepted within 500 cycles");
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (mon_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (mon_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait timeout: got %0d beats required %0d", mon_q.size(), n);
    end
  endtask

  vec_t   vt[8];
  ibeat_t ib;
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  int     exp_len[$];
  logic [7:0] exp_ctl[$];

  initial begin
    int acc_cyc, total, nb, pkt, pos, base, len;
    logic [15:0] ed;
    logic ee;

    vt[0] = '{'{64'h0807060504030201, 1'b1, 1'b1, 3'd0, 8'hA5, 1'b0}, 4, 1'b0};
    vt[1] = '{'{64'h1122334455667788, 1'b1, 1'b0, 3'd5, 8'h3C, 1'b0}, 4, 1'b0};
    vt[2] = '{'{64'h99AABBCCDDEEFF00, 1'b0, 1'b1, 3'd3, 8'h3C, 1'b0}, 2, 1'b1};
    vt[3] = '{'{64'h00000000000000C3, 1'b1, 1'b1, 3'd1, 8'h0F, 1'b1}, 1, 1'b1};
    vt[4] = '{'{64'h000000000000BEEF, 1'b1, 1'b1, 3'd2, 8'hF0, 1'b0}, 1, 1'b0};
    vt[5] = '{'{64'h7766554433221100, 1'b1, 1'b1, 3'd7, 8'h81, 1'b1}, 4, 1'b1};
    vt[6] = '{'{64'hCAFEF00DDEADBEEF, 1'b1, 1'b1, 3'd6, 8'h42, 1'b0}, 3, 1'b0};
    vt[7] = '{'{64'h0123456789ABCDEF, 1'b1, 1'b1, 3'd4, 8'h24, 1'b0}, 2, 1'b0};

    in_if.val = 1'b0;
    in_if.dat = '0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
    in_if.mod = '0;
    in_if.ctl = '0;
    in_if.err = 1'b0;

    // Reset state
    #1;
    check("rst out val", out_if.val, 0);
    check("rst in rdy", in_if.rdy, 0);
    check("rst out dat", out_if.dat, 0);
    check("rst out sop", out_if.sop, 0);
    check("rst out ctl", out_if.ctl, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post rst in rdy", in_if.rdy, 1);
    @(posedge clk);
    #1;

    // Single-beat vectors: count, latency and every field of every output beat
    for (int i = 0; i < 8; i++) begin
      mon_q.delete();
      drive_beat(vt[i].in);
      acc_cyc = cyc;
      wait_beats(vt[i].exp_n, 50);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("vec%0d count", i), mon_q.size(), vt[i].exp_n);
      for (int k = 0; k < mon_q.size() && k < vt[i].exp_n; k++) begin
        ed = 16'(vt[i].in.dat >> (16 * k));
        ee = vt[i].in.eop && (k == vt[i].exp_n - 1);
        check($sformatf("vec%0d b%0d dat", i, k), mon_q[k].dat, ed);
        check($sformatf("vec%0d b%0d sop", i, k), mon_q[k].sop, vt[i].in.sop && (k == 0));
        check($sformatf("vec%0d b%0d eop", i, k), mon_q[k].eop, ee);
        check($sformatf("vec%0d b%0d mod", i, k), mon_q[k].mod, ee ? vt[i].exp_lmod : 1'b0);
        check($sformatf("vec%0d b%0d ctl", i, k), mon_q[k].ctl, vt[i].in.ctl);
        check($sformatf("vec%0d b%0d err", i, k), mon_q[k].err, vt[i].in.err);
        check($sformatf("vec%0d b%0d cyc", i, k), mon_q[k].cyc, acc_cyc + k);
      end
    end

    // 3-byte packet immediately followed by an 8-byte packet: no idle output cycle
    mon_q.delete();
    drive_beat('{64'h44332211DDCCBBAA, 1'b1, 1'b1, 3'd3, 8'h11, 1'b0});
    drive_beat('{64'h0807060504030201, 1'b1, 1'b1, 3'd0, 8'h22, 1'b0});
    wait_beats(6, 50);
    repeat (4) @(posedge clk);
    #1;
    check("b2b count", mon_q.size(), 6);
    if (mon_q.size() >= 6) begin
      for (int k = 1; k < 6; k++)
        check($sformatf("b2b cyc%0d", k), mon_q[k].cyc, mon_q[0].cyc + k);
      check("b2b b1 dat", mon_q[1].dat, 16'hDDCC);
      check("b2b b1 eop", mon_q[1].eop, 1);
      check("b2b b1 mod", mon_q[1].mod, 1);
      check("b2b b1 ctl", mon_q[1].ctl, 8'h11);
      check("b2b b2 sop", mon_q[2].sop, 1);
      check("b2b b2 dat", mon_q[2].dat, 16'h0201);
      check("b2b b2 ctl", mon_q[2].ctl, 8'h22);
      check("b2b b5 dat", mon_q[5].dat, 16'h0807);
      check("b2b b5 eop", mon_q[5].eop, 1);
    end

    // 11-byte packet; the non-eop beat carries a stray mod that must be ignored
    mon_q.delete();
    drive_beat('{64'h1716151413121110, 1'b1, 1'b0, 3'd5, 8'h5E, 1'b0});
    drive_beat('{64'hFFFFFFFFFF1A1918, 1'b0, 1'b1, 3'd3, 8'h5E, 1'b0});
    wait_beats(6, 50);
    repeat (4) @(posedge clk);
    #1;
    check("p11 count", mon_q.size(), 6);
    got_bytes.delete();
    foreach (mon_q[k]) begin
      nb = mon_q[k].eop ? ((mon_q[k].mod == 0) ? 2 : int'(mon_q[k].mod)) : 2;
      for (int j = 0; j < nb; j++) got_bytes.push_back(mon_q[k].dat[8*j +: 8]);
    end
    check("p11 len", got_bytes.size(), 11);
    for (int j = 0; j < got_bytes.size() && j < 11; j++)
      check($sformatf("p11 byte%0d", j), got_bytes[j], 8'h10 + 8'(j));
    if (mon_q.size() >= 6) begin
      check("p11 last dat lo", mon_q[5].dat[7:0], 8'h1A);
      check("p11 last eop", mon_q[5].eop, 1);
      check("p11 last mod", mon_q[5].mod, 1);
    end

    // Random-length packets under random output backpressure
    mon_q.delete();
    exp_bytes.delete();
    exp_len.delete();
    exp_ctl.delete();
    total = 0;
    bp_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 64);
      exp_len.push_back(len);
      exp_ctl.push_back(8'($urandom));
      total += (len + 1) / 2;
      base = exp_bytes.size();
      for (int j = 0; j < len; j++) exp_bytes.push_back(8'($urandom));
      for (int off = 0; off < len; off += 8) begin
        ib.dat = {$urandom, $urandom};
        for (int j = 0; j < 8 && off + j < len; j++) ib.dat[8*j +: 8] = exp_bytes[base + off + j];
        ib.sop = (off == 0);
        ib.eop = (off + 8 >= len);
        ib.mod = ib.eop ? 3'((len - off) % 8) : 3'($urandom);
        ib.ctl = exp_ctl[p];
        ib.err = 1'b0;
        drive_beat(ib);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_beats(total, 20000);
    bp_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp beat count", mon_q.size(), total);
    pkt = 0;
    pos = 0;
    base = 0;
    foreach (mon_q[k]) begin
      if (pkt >= exp_len.size()) begin
        check("bp extra beat", 1, 0);
        break;
      end
      len = exp_len[pkt];
      ee = (len - pos) <= 2;
      nb = ee ? (len - pos) : 2;
      check("bp sop", mon_q[k].sop, pos == 0);
      check("bp eop", mon_q[k].eop, ee);
      check("bp mod", mon_q[k].mod, ee ? 1'((len - pos) % 2) : 1'b0);
      check("bp ctl", mon_q[k].ctl, exp_ctl[pkt]);
      for (int j = 0; j < nb; j++)
        check("bp byte", mon_q[k].dat[8*j +: 8], exp_bytes[base + pos + j]);
      pos += nb;
      if (ee) begin
        base += len;
        pos = 0;
        pkt++;
      end
    end
    check("bp packets", pkt, 200);

    // Reset after output beat 2 of 4
    mon_q.delete();
    drive_beat('{64'h0807060504030201, 1'b1, 1'b1, 3'd0, 8'h5A, 1'b0});
    for (int t = 0; t < 50 && mon_q.size() < 2; t++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst beats", mon_q.size(), 2);
    check("midrst val", out_if.val, 0);
    check("midrst in rdy", in_if.rdy, 0);
    check("midrst dat", out_if.dat, 0);
    check("midrst sop", out_if.sop, 0);
    check("midrst ctl", out_if.ctl, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst no partial", mon_q.size(), 2);
    mon_q.delete();
    drive_beat('{64'h2827262524232221, 1'b1, 1'b1, 3'd0, 8'h77, 1'b0});
    wait_beats(4, 50);
    repeat (3) @(posedge clk);
    #1;
    check("postrst count", mon_q.size(), 4);
    if (mon_q.size() >= 4) begin
      check("postrst b0 sop", mon_q[0].sop, 1);
      check("postrst b0 dat", mon_q[0].dat, 16'h2221);
      check("postrst b3 dat", mon_q[3].dat, 16'h2827);
      check("postrst b3 eop", mon_q[3].eop, 1);
      check("postrst ctl", mon_q[3].ctl, 8'h77);
    end

`ifdef AXIS_WIDTH_DOWN_PROTO_CHK_EN
    check("proto clean", proto_err, 0);
    drive_beat('{64'h0000000000003412, 1'b0, 1'b1, 3'd2, 8'h01, 1'b0});
    check("proto set", proto_err, 1);
    repeat (10) @(posedge clk);
    #1;
    check("proto sticky", proto_err, 1);
    rst_n = 1'b0;
    #1;
    check("proto reset", proto_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
